// File: rtl/prbs_checker.sv
// Receive-side checker for the 16-bit XNOR PRBS (taps 15,13,12,10): self-syncs, then counts word errors.
// Define PRBS_CHK_STUCK_EN to enable detection of the all-ones lockup word on the stuck output.
module prbs_checker #(
  parameter int LOCK_CNT = 8,
  parameter int LOSS_CNT = 4,
  parameter int ERR_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [15:0]      in_data,
  input  logic             clr_count,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic             stuck
);

  typedef enum logic [1:0] {IDLE, SEARCH, LOCKED} state_t;

  localparam logic [7:0] LOCK_TC = 8'(LOCK_CNT);
  localparam logic [7:0] LOSS_TC = 8'(LOSS_CNT);

  state_t      state, state_nx;
  logic [15:0] pred, pred_nx;
  logic [7:0]  match_cnt, match_nx;
  logic [7:0]  miss_cnt, miss_nx;
  logic        err_nx;
  logic        search_ok;

  function automatic logic [15:0] prbs_next(input logic [15:0] x);
    return {x[14:0], ~(x[15] ^ x[13] ^ x[12] ^ x[10])};
  endfunction

`ifdef PRBS_CHK_STUCK_EN
  logic       ones_word;
  logic [7:0] ones_run;

  assign ones_word = (in_data == 16'hFFFF);
  // The lockup word predicts itself, so it must never be allowed to build lock.
  assign search_ok = (in_data == pred) && !ones_word;

  always_ff @(posedge clk) begin
    if (reset) begin
      ones_run <= 8'd0;
      stuck    <= 1'b0;
    end else if (in_valid) begin
      if (ones_word) begin
        if (ones_run != LOCK_TC) ones_run <= ones_run + 8'd1;
        stuck <= (ones_run >= LOCK_TC - 8'd1);
      end else begin
        ones_run <= 8'd0;
        stuck    <= 1'b0;
      end
    end
  end
`else
  assign search_ok = (in_data == pred);
  assign stuck     = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    pred_nx  = pred;
    match_nx = match_cnt;
    miss_nx  = miss_cnt;
    err_nx   = 1'b0;
    if (in_valid) begin
      unique case (state)
        IDLE: begin
          pred_nx  = prbs_next(in_data);
          state_nx = SEARCH;
        end
        SEARCH: begin
          pred_nx = prbs_next(in_data);
          if (search_ok) begin
            match_nx = match_cnt + 8'd1;
            if (match_nx == LOCK_TC) begin
              state_nx = LOCKED;
              miss_nx  = 8'd0;
            end
          end else begin
            match_nx = 8'd0;
          end
        end
        LOCKED: begin
          // Flywheel: keep predicting from our own sequence so one bad word costs one error.
          pred_nx = prbs_next(pred);
          if (in_data == pred) begin
            miss_nx = 8'd0;
          end else begin
            err_nx  = 1'b1;
            miss_nx = miss_cnt + 8'd1;
            if (miss_nx == LOSS_TC) begin
              state_nx = SEARCH;
              match_nx = 8'd0;
              pred_nx  = prbs_next(in_data);
            end
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      pred      <= 16'd0;
      match_cnt <= 8'd0;
      miss_cnt  <= 8'd0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= state_nx;
      pred      <= pred_nx;
      match_cnt <= match_nx;
      miss_cnt  <= miss_nx;
      locked    <= (state_nx == LOCKED);
      err_pulse <= err_nx;
      if (clr_count) begin
        err_count <= '0;
      end else if (err_nx && (err_count != '1)) begin
        err_count <= err_count + ERR_W'(1);
      end
    end
  end

endmodule
